// File: rtl/display_7seg_scan_pkg.sv
// disp7_pkg: segment patterns and digit width shared by the 7-segment scan driver.
`default_nettype none

package disp7_pkg;

  localparam int DIGIT_W = 4;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b1111100;
  localparam logic [6:0] SEG_C     = 7'b0111001;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_F     = 7'b1110001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_ALL   = 7'b1111111;

endpackage

`default_nettype wire

// File: rtl/display_7seg_scan_bcd_to_7seg.sv
// bcd_to_7seg: combinational 4-bit code to segment decoder, rev 1.0.
// Optional macro DISP7_HEX_EN: codes 10-15 show A,b,C,d,E,F instead of blank.
`default_nettype none

module bcd_to_7seg
  import disp7_pkg::*;
(
  input  logic [DIGIT_W-1:0] code,
  output logic [6:0]         seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
`ifdef DISP7_HEX_EN
      4'd10:   seg = SEG_A;
      4'd11:   seg = SEG_B;
      4'd12:   seg = SEG_C;
      4'd13:   seg = SEG_D;
      4'd14:   seg = SEG_E;
      4'd15:   seg = SEG_F;
`endif
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/display_7seg_scan.sv
// display_7seg_scan: multiplexed N-digit 7-segment driver with lamp test and blanking, rev 1.0.
// Optional macro DISP7_HEX_EN enables hex glyphs for codes 10-15.
`default_nettype none

module display_7seg_scan
  import disp7_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int PRESCALE = 50000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DIGIT_W*N_DIGITS-1:0] bcd_in,
  input  logic [N_DIGITS-1:0]         dp_in,
  input  logic                        le,
  input  logic                        lt_n,
  input  logic                        bi_n,
  output logic [6:0]                  seg,
  output logic                        dp,
  output logic [N_DIGITS-1:0]         an
);

  // A one-digit build still needs a 1-bit index register.
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PS_W  = $clog2(PRESCALE);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [DIGIT_W*N_DIGITS-1:0] bcd_q;
  logic [N_DIGITS-1:0]         dp_q;
  logic [PS_W-1:0]             presc;
  logic [IDX_W-1:0]            idx;
  logic [DIGIT_W-1:0]          digit;
  logic                        digit_dp;
  logic [N_DIGITS-1:0]         onehot;
  logic [6:0]                  dec_seg;

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q <= '0;
      dp_q  <= '0;
    end else if (!le) begin
      bcd_q <= bcd_in;
      dp_q  <= dp_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PS_LAST) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_comb begin
    digit    = '0;
    digit_dp = 1'b0;
    onehot   = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        digit     = bcd_q[k*DIGIT_W +: DIGIT_W];
        digit_dp  = dp_q[k];
        onehot[k] = 1'b1;
      end
    end
  end

  bcd_to_7seg u_dec (
    .code (digit),
    .seg  (dec_seg)
  );

  // Lamp test outranks blanking; seg, dp and an all update on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_BLANK;
      dp  <= 1'b0;
      an  <= '0;
    end else if (!lt_n) begin
      seg <= SEG_ALL;
      dp  <= 1'b1;
      an  <= onehot;
    end else if (!bi_n) begin
      seg <= SEG_BLANK;
      dp  <= 1'b0;
      an  <= '0;
    end else begin
      seg <= dec_seg;
      dp  <= digit_dp;
      an  <= onehot;
    end
  end

endmodule

`default_nettype wire
